// File: rtl/sa_c_collector.sv
// Bottom-edge C collector: de-skews per-column array outputs into column FIFOs and
// presents aligned C rows on a valid/ready handshake. Optional sticky overflow: SA_C_COLLECTOR_OVF_EN.
module sa_c_collector #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SIZE  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SIZE-1:0]         i_c_vld,
    input  logic [SIZE*WIDTH-1:0]   i_c_rows,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic [SIZE*WIDTH-1:0]   o_rows,
    output logic                    o_last,
    output logic                    o_full
`ifdef SA_C_COLLECTOR_OVF_EN
    ,
    output logic                    o_ovf
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned RW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(SIZE - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem_q [SIZE][DEPTH];
    logic [PW-1:0]    wptr_q [SIZE];
    logic [PW-1:0]    wptr_d [SIZE];
    logic [PW-1:0]    rptr_q [SIZE];
    logic [PW-1:0]    rptr_d [SIZE];
    logic [PW-1:0]    cnt    [SIZE];
    logic [SIZE-1:0]  col_full;
    logic [SIZE-1:0]  col_empty;
    logic [SIZE-1:0]  push;
    logic             pop;
    logic [RW-1:0]    rowcnt_q;
    logic [RW-1:0]    rowcnt_d;

    // Occupancy comes only from registered pointers, so o_vld never sees i_c_vld.
    always_comb begin
        col_full  = '0;
        col_empty = '0;
        for (int j = 0; j < SIZE; j++) begin
            cnt[j]       = wptr_q[j] - rptr_q[j];
            col_full[j]  = (cnt[j] == FULL_CNT);
            col_empty[j] = (cnt[j] == '0);
        end
    end

    assign o_vld  = ~|col_empty;
    assign pop    = o_vld & i_rdy;
    assign o_last = o_vld & (rowcnt_q == LAST_ROW);
    assign o_full = |col_full;

    // A full column still accepts a push when the same-cycle pop frees its head slot.
    always_comb begin
        push   = '0;
        o_rows = '0;
        for (int j = 0; j < SIZE; j++) begin
            push[j]   = i_c_vld[j] & (~col_full[j] | pop);
            wptr_d[j] = push[j] ? wptr_q[j] + PW'(1) : wptr_q[j];
            rptr_d[j] = pop ? rptr_q[j] + PW'(1) : rptr_q[j];
            o_rows[j*WIDTH +: WIDTH] = mem_q[j][rptr_q[j][AW-1:0]];
        end
    end

    always_comb begin
        rowcnt_d = rowcnt_q;
        if (pop) begin
            rowcnt_d = (rowcnt_q == LAST_ROW) ? '0 : rowcnt_q + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < SIZE; j++) begin
                wptr_q[j] <= '0;
                rptr_q[j] <= '0;
            end
            rowcnt_q <= '0;
        end else begin
            for (int j = 0; j < SIZE; j++) begin
                wptr_q[j] <= wptr_d[j];
                rptr_q[j] <= rptr_d[j];
            end
            rowcnt_q <= rowcnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < SIZE; j++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    mem_q[j][k] <= '0;
                end
            end
        end else begin
            for (int j = 0; j < SIZE; j++) begin
                if (push[j]) begin
                    mem_q[j][wptr_q[j][AW-1:0]] <= i_c_rows[j*WIDTH +: WIDTH];
                end
            end
        end
    end

`ifdef SA_C_COLLECTOR_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (|(i_c_vld & col_full) && !pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sa_c_collector.sv
// Randomized and directed bench for sa_c_collector against a queue-based reference model.
module tb_sa_c_collector;
    localparam int W = 16;
    localparam int S = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [S-1:0]   c_vld;
    logic [S*W-1:0] c_rows;
    logic           vld;
    logic           rdy;
    logic [S*W-1:0] rows;
    logic           last;
    logic           full;
    logic           ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] q [S][$];
    int           rc;
    bit           ovf_m;

    always #5 clk = ~clk;

    sa_c_collector #(.WIDTH(W), .SIZE(S), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_c_vld  (c_vld),
        .i_c_rows (c_rows),
        .o_vld    (vld),
        .i_rdy    (rdy),
        .o_rows   (rows),
        .o_last   (last),
        .o_full   (full)
`ifdef SA_C_COLLECTOR_OVF_EN
        ,
        .o_ovf    (ovf)
`endif
    );

`ifndef SA_C_COLLECTOR_OVF_EN
    assign ovf = 1'b0;
`endif

    function automatic bit m_vld();
        for (int j = 0; j < S; j++) if (q[j].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int j = 0; j < S; j++) if (q[j].size() == D) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_last();
        return m_vld() && (rc == S - 1);
    endfunction

    function automatic logic [S*W-1:0] m_row();
        logic [S*W-1:0] r = '0;
        for (int j = 0; j < S; j++) if (q[j].size() > 0) r[j*W +: W] = q[j][0];
        return r;
    endfunction

    function automatic logic [S*W-1:0] mk_row(int r);
        logic [S*W-1:0] v = '0;
        for (int j = 0; j < S; j++) v[j*W +: W] = 16'((r + 1) * 256 + j + 1);
        return v;
    endfunction

    // Skewed stream: column j carries row (t - j); rows >= nrows are not sent,
    // except row nrows on column 0 when partial is set.
    task automatic drive_skew(int t, int nrows, bit partial);
        logic [S*W-1:0] ref_row;
        c_vld  = '0;
        c_rows = {$urandom(), $urandom()};
        for (int j = 0; j < S; j++) begin
            int r = t - j;
            if ((r >= 0 && r < nrows) || (partial && j == 0 && r == nrows)) begin
                ref_row = mk_row(r);
                c_vld[j] = 1'b1;
                c_rows[j*W +: W] = ref_row[j*W +: W];
            end
        end
    endtask

    // Advance the reference model by one clock using the currently driven inputs.
    task automatic tick();
        bit p;
        bit acc [S];
        p = m_vld() && rdy;
        for (int j = 0; j < S; j++) begin
            acc[j] = c_vld[j] && (q[j].size() < D || p);
            if (c_vld[j] && !acc[j]) ovf_m = 1'b1;
        end
        if (p) begin
            for (int j = 0; j < S; j++) void'(q[j].pop_front());
            rc = (rc + 1) % S;
        end
        for (int j = 0; j < S; j++) if (acc[j]) q[j].push_back(c_rows[j*W +: W]);
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int j = 0; j < S; j++) q[j].delete();
        rc    = 0;
        ovf_m = 1'b0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        c_vld  = '0;
        c_rows = '0;
        rdy    = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        c_vld  = '0;
        c_rows = '0;
        rdy    = 1'b0;
        #1;
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got=%b exp=0", vld); end
        n_cmp++; if (rows !== '0) begin n_err++; $display("FAIL reset_rows got=%h exp=0", rows); end
        n_cmp++; if (last !== 1'b0) begin n_err++; $display("FAIL reset_last got=%b exp=0", last); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
`ifdef SA_C_COLLECTOR_OVF_EN
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        do_reset();
    endtask

    task automatic test_single_row();
        do_reset();
        rdy = 1'b1;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            n_cmp++;
            if (vld !== (cyc == 14)) begin
                n_err++; $display("FAIL single_vld cyc=%0d got=%b exp=%b", cyc, vld, cyc == 14);
            end
            if (cyc == 14) begin
                n_cmp++;
                if (rows !== 64'h0044_0033_0022_0011) begin
                    n_err++; $display("FAIL single_rows got=%h exp=%h", rows, 64'h0044_0033_0022_0011);
                end
                n_cmp++; if (last !== 1'b0) begin n_err++; $display("FAIL single_last got=%b exp=0", last); end
            end
            c_vld  = '0;
            c_rows = {$urandom(), $urandom()};
            if (cyc >= 10 && cyc <= 13) begin
                c_vld[cyc-10] = 1'b1;
                c_rows[(cyc-10)*W +: W] = 16'(17 * (cyc - 9));
            end
            tick();
        end
    endtask

    task automatic test_matrix_stream();
        do_reset();
        rdy = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            bit ev = (t >= 4 && t <= 7);
            n_cmp++; if (vld !== ev) begin n_err++; $display("FAIL stream_vld t=%0d got=%b exp=%b", t, vld, ev); end
            if (ev) begin
                n_cmp++;
                if (rows !== mk_row(t - 4)) begin
                    n_err++; $display("FAIL stream_rows t=%0d got=%h exp=%h", t, rows, mk_row(t - 4));
                end
                n_cmp++;
                if (last !== (t == 7)) begin n_err++; $display("FAIL stream_last t=%0d got=%b exp=%b", t, last, t == 7); end
            end
            drive_skew(t, 4, 1'b0);
            tick();
        end
        // One more row, all columns at once: the row counter must have wrapped to 0.
        c_vld  = '1;
        c_rows = mk_row(7);
        tick();
        c_vld = '0;
        n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL wrap_vld got=%b exp=1", vld); end
        n_cmp++; if (last !== 1'b0) begin n_err++; $display("FAIL wrap_last got=%b exp=0", last); end
        tick();
    endtask

    task automatic fill_four_rows();
        rdy = 1'b0;
        for (int t = 0; t <= 6; t++) begin
            drive_skew(t, 4, 1'b0);
            tick();
        end
        c_vld = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        fill_four_rows();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL bp_vld k=%0d got=%b exp=1", k, vld); end
            n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL bp_full k=%0d got=%b exp=1", k, full); end
            n_cmp++; if (rows !== mk_row(0)) begin n_err++; $display("FAIL bp_hold k=%0d got=%h exp=%h", k, rows, mk_row(0)); end
            tick();
        end
        c_vld  = 4'b0001;
        c_rows = {48'h0, 16'hDEAD};
        tick();
        c_vld = '0;
`ifdef SA_C_COLLECTOR_OVF_EN
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL bp_ovf got=%b exp=1", ovf); end
`endif
        rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL bp_drain_vld k=%0d got=%b exp=1", k, vld); end
            n_cmp++; if (rows !== mk_row(k)) begin n_err++; $display("FAIL bp_drain_rows k=%0d got=%h exp=%h", k, rows, mk_row(k)); end
            n_cmp++; if (last !== (k == 3)) begin n_err++; $display("FAIL bp_drain_last k=%0d got=%b exp=%b", k, last, k == 3); end
`ifdef SA_C_COLLECTOR_OVF_EN
            n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL bp_ovf_sticky k=%0d got=%b exp=1", k, ovf); end
`endif
            tick();
        end
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%b exp=0", vld); end
    endtask

    task automatic test_push_pop_full();
        logic [S*W-1:0] aa = {4{16'h00AA}};
        do_reset();
        fill_four_rows();
        rdy    = 1'b1;
        c_vld  = '1;
        c_rows = aa;
        tick();
        c_vld = '0;
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ppf_full got=%b exp=1", full); end
`ifdef SA_C_COLLECTOR_OVF_EN
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ppf_ovf got=%b exp=0", ovf); end
`endif
        for (int k = 1; k <= 4; k++) begin
            logic [S*W-1:0] exp_r = (k == 4) ? aa : mk_row(k);
            n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL ppf_vld k=%0d got=%b exp=1", k, vld); end
            n_cmp++; if (rows !== exp_r) begin n_err++; $display("FAIL ppf_rows k=%0d got=%h exp=%h", k, rows, exp_r); end
            n_cmp++; if (last !== (k == 3)) begin n_err++; $display("FAIL ppf_last k=%0d got=%b exp=%b", k, last, k == 3); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int nrow = 0;
        do_reset();
        rdy = 1'b0;
        for (int t = 0; t <= 4; t++) begin
            drive_skew(t, 2, 1'b1);
            tick();
        end
        c_vld = '0;
        n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL mid_pre_vld got=%b exp=1", vld); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL mid_vld got=%b exp=0", vld); end
        n_cmp++; if (rows !== '0) begin n_err++; $display("FAIL mid_rows got=%h exp=0", rows); end
        n_cmp++; if (last !== 1'b0) begin n_err++; $display("FAIL mid_last got=%b exp=0", last); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL mid_full got=%b exp=0", full); end
`ifdef SA_C_COLLECTOR_OVF_EN
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL mid_ovf got=%b exp=0", ovf); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        rdy = 1'b1;
        for (int t = 0; t <= 10; t++) begin
            n_cmp++; if (vld !== m_vld()) begin n_err++; $display("FAIL post_vld t=%0d got=%b exp=%b", t, vld, m_vld()); end
            if (m_vld()) begin
                n_cmp++; if (last !== (nrow == 3)) begin n_err++; $display("FAIL post_last row=%0d got=%b exp=%b", nrow, last, nrow == 3); end
                n_cmp++; if (rows !== mk_row(nrow)) begin n_err++; $display("FAIL post_rows row=%0d got=%h exp=%h", nrow, rows, mk_row(nrow)); end
                nrow++;
            end
            drive_skew(t, 4, 1'b0);
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_cmp++; if (vld !== m_vld()) begin n_err++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, vld, m_vld()); end
            n_cmp++; if (full !== m_full()) begin n_err++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, full, m_full()); end
            n_cmp++; if (last !== m_last()) begin n_err++; $display("FAIL rnd_last cyc=%0d got=%b exp=%b", cyc, last, m_last()); end
            if (m_vld()) begin
                n_cmp++; if (rows !== m_row()) begin n_err++; $display("FAIL rnd_rows cyc=%0d got=%h exp=%h", cyc, rows, m_row()); end
            end
`ifdef SA_C_COLLECTOR_OVF_EN
            n_cmp++; if (ovf !== ovf_m) begin n_err++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", cyc, ovf, ovf_m); end
`endif
            c_vld  = S'($urandom());
            c_rows = {$urandom(), $urandom()};
            rdy    = ($urandom_range(0, 3) != 0);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_matrix_stream();
        test_backpressure();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sa_c_collector.md
Name: sa_c_collector

Overview:
- Receiver for the systolic array's bottom-edge C outputs.
- The array emits C row elements skewed in time: column j's element arrives j cycles after column 0's, each qualified by its own per-column valid.
- This block de-skews the elements into per-column FIFOs and presents complete, aligned C rows on a valid/ready handshake.
- The array cannot stall, so this block provides full and overflow indications back to the array-side controller.

Parameters:
- WIDTH, 16, element width in bits; matches the array.
- SIZE, 4, number of array columns, and rows per C matrix.
- DEPTH, 4, per-column FIFO depth in entries. Power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_c_vld  in  SIZE  per-column element valid from the array bottom edge.
- i_c_rows  in  SIZE*WIDTH  per-column elements; slice j belongs to column j.
- o_vld  out  1  a complete aligned C row is available.
- i_rdy  in  1  consumer accepts the row; a pop occurs when o_vld and i_rdy are both 1.
- o_rows  out  SIZE*WIDTH  aligned C row; slice j is the head of column FIFO j.
- o_last  out  1  the presented row is the last (row SIZE-1) of the current C matrix.
- o_full  out  1  at least one column FIFO holds DEPTH entries.
- o_ovf  out  1  sticky overflow flag. Present only with the optional feature; see below.

Behaviour:
- Storage: one FIFO per column, each DEPTH x WIDTH. Read and write pointers are clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Entry count = wptr - rptr.
- Push, column j: when i_c_vld[j]=1 and either count_j < DEPTH or a pop occurs in the same cycle, write i_c_rows[j] at wptr_j, then increment wptr_j.
- Push to a full column with no pop that cycle: data is dropped and wptr_j is unchanged.
- Columns push independently. Pushes to several columns in one cycle are all accepted.
- o_vld = 1 exactly when every count_j >= 1. It is derived from registered counts only, with no combinational path from i_c_vld.
- o_rows[j] = mem_j[rptr_j]. It is held stable while o_vld=1 and i_rdy=0.
- Pop: when o_vld and i_rdy are both 1, increment every rptr_j in the same cycle.
- Latency: if column SIZE-1 receives the last element of a row on edge N, o_vld rises after edge N, i.e. it is visible in the cycle after the write. Sustained throughput is 1 row per cycle.
- Row counter: rowcnt runs 0..SIZE-1 and increments on each pop, wrapping from SIZE-1 to 0. o_last = o_vld and (rowcnt == SIZE-1).
- o_full = 1 when any count_j == DEPTH, from registered state.
- Simultaneous push and pop on the same column, including at count DEPTH: both take effect and the count is unchanged.
- A pop with count_j == 0 is impossible, because o_vld would be 0.
- Reset, asynchronous and usable at any time including mid-row or mid-matrix:
  - all pointers go to 0, rowcnt to 0, FIFO memories to 0;
  - o_vld=0, o_rows=0, o_last=0, o_full=0, o_ovf=0;
  - partially collected rows are discarded.
  - The first row accepted after reset is row 0 of a new matrix.

Optional Feature:
- Macro: SA_C_COLLECTOR_OVF_EN.
- Defined:
  - o_ovf is set on any attempted push to a full column with no same-cycle pop.
  - It stays set until rst, and the dropped data is discarded.
- Not defined:
  - the o_ovf port and its logic are removed;
  - overflowing pushes are still silently dropped;
  - all other behaviour is identical.

Test Plan:
- SIZE=4, WIDTH=16, DEPTH=4.
- Single skewed row: i_c_vld[j] pulsed at cycle 10+j with values 0x0011, 0x0022, 0x0033, 0x0044 and i_rdy=1 -> o_vld=1 only in cycle 14; o_rows[0..3] = 0x0011, 0x0022, 0x0033, 0x0044; o_last=0.
- Full matrix streamed: 4 skewed rows back-to-back with i_rdy=1 -> o_vld high for 4 consecutive cycles, rows in order; o_last=1 only on the 4th; rowcnt back to 0.
- Backpressure: i_rdy=0 while 4 rows are pushed -> o_full=1, o_vld held with row 0 stable. A 5th element to column 0 -> dropped, o_ovf=1 (with macro). Then i_rdy=1 -> rows 0..3 emerge in order; o_ovf stays 1.
- Push and pop at full: all columns at count 4, i_rdy=1, and i_c_vld=4'b1111 with value 0x00AA -> count stays 4, no overflow. 0x00AA appears as the 4th subsequent row.
- Reset mid-operation: 2 rows queued and column 0 holding a partial 3rd row; rst pulsed for 1 cycle -> all outputs 0 immediately. The next full row produces o_vld with o_last=0, and the 4th row after reset has o_last=1.
